// File: rtl/sd_pkg.sv
// Shared types and constants for the SD command engine.
package sd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TX,
    WAIT,
    RX,
    NCC
  } state_t;

  localparam logic [6:0] CRC_POLY = 7'h09;
  localparam int FRAME_LEN = 48;
  localparam int NCC_LEN = 8;
  // Bits covered by CRC7: start, direction, index and argument.
  localparam int CRC_BITS = FRAME_LEN - 8;

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), MSB first, zero seed.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic fb;

  assign fb = din ^ crc[6];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= {crc[5:0], 1'b0} ^ (fb ? CRC_POLY : 7'h00);
    end
  end

endmodule

// File: rtl/sd_cmd_engine.sv
// SD CMD-line engine: sd_clk divider, command serialiser,
// response capture with CRC7 check and timeout.
module sd_cmd_engine
  import sd_pkg::*;
#(
  parameter int CLKDIV  = 31,
  parameter int NCR_MAX = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic        cmd_resp,
  output logic        resp_valid,
  output logic [5:0]  resp_index,
  output logic [31:0] resp_arg,
  output logic        resp_crc_err,
  output logic        resp_timeout,
  output logic        sd_clk,
  output logic        sd_cmd_o,
  output logic        sd_cmd_oe,
  input  logic        sd_cmd_i
);

  localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

  logic [DW-1:0] div;
  logic          wrap;
  logic          fall_tick;
  logic          rise_tick;

  assign wrap      = (div == DW'(CLKDIV - 1));
  assign fall_tick = wrap && sd_clk;
  assign rise_tick = wrap && !sd_clk;

  always_ff @(posedge clk) begin
    if (rst) begin
      div    <= '0;
      sd_clk <= 1'b0;
    end else if (wrap) begin
      div    <= '0;
      sd_clk <= ~sd_clk;
    end else begin
      div <= div + 1'b1;
    end
  end

  logic [1:0] sync;
  logic       samp;

  assign samp = sync[1];

  always_ff @(posedge clk) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], sd_cmd_i};
  end

  state_t      state;
  logic [15:0] cnt;
  logic [39:0] tx_sh;
  logic [45:0] rx_sh;
  logic [46:0] rx_full;
  logic        want_resp;
  logic        accept;
  logic        crc_clr;
  logic        crc_en;
  logic        crc_din;
  logic [6:0]  crc;

  assign accept  = (state == IDLE) && cmd_valid && cmd_ready;
  // Start bit is never stored; rx_full is frame bits 46..0.
  assign rx_full = {rx_sh, samp};

  always_comb begin
    crc_clr = accept || (state == WAIT);
    crc_en  = 1'b0;
    crc_din = samp;
    unique case (1'b1)
      (state == TX): begin
        crc_en  = fall_tick && cnt < 16'(CRC_BITS);
        crc_din = tx_sh[39];
      end
      (state == RX): begin
        crc_en = rise_tick && cnt < 16'(CRC_BITS);
      end
      default: ;
    endcase
  end

  sd_crc7 u_crc (
    .clk (clk),
    .rst (rst),
    .clr (crc_clr),
    .en  (crc_en),
    .din (crc_din),
    .crc (crc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      tx_sh        <= '0;
      rx_sh        <= '0;
      want_resp    <= 1'b0;
      cmd_ready    <= 1'b1;
      sd_cmd_oe    <= 1'b0;
      sd_cmd_o     <= 1'b1;
      resp_valid   <= 1'b0;
      resp_index   <= '0;
      resp_arg     <= '0;
      resp_crc_err <= 1'b0;
      resp_timeout <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            tx_sh        <= {2'b01, cmd_index, cmd_arg};
            want_resp    <= cmd_resp;
            resp_index   <= '0;
            resp_arg     <= '0;
            resp_crc_err <= 1'b0;
            resp_timeout <= 1'b0;
            cmd_ready    <= 1'b0;
            cnt          <= '0;
            state        <= TX;
          end
        end
        TX: begin
          if (fall_tick) begin
            if (cnt == 16'(FRAME_LEN)) begin
              sd_cmd_oe <= 1'b0;
              sd_cmd_o  <= 1'b1;
              cnt       <= '0;
              state     <= want_resp ? WAIT : NCC;
            end else begin
              sd_cmd_oe <= 1'b1;
              cnt       <= cnt + 16'd1;
              // CRC is final here; park its tail and the end bit.
              if (cnt == 16'(CRC_BITS)) begin
                sd_cmd_o      <= crc[6];
                tx_sh[39:33]  <= {crc[5:0], 1'b1};
              end else begin
                sd_cmd_o <= tx_sh[39];
                tx_sh    <= {tx_sh[38:0], 1'b0};
              end
            end
          end
        end
        WAIT: begin
          if (rise_tick) begin
            if (!samp) begin
              rx_sh <= '0;
              cnt   <= 16'd1;
              state <= RX;
            end else if (cnt == 16'(NCR_MAX - 1)) begin
              resp_timeout <= 1'b1;
              cnt          <= '0;
              state        <= NCC;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        RX: begin
          if (rise_tick) begin
            rx_sh <= rx_full[45:0];
            if (cnt == 16'(FRAME_LEN - 1)) begin
              resp_index   <= rx_full[45:40];
              resp_arg     <= rx_full[39:8];
              resp_crc_err <= rx_full[46] || (rx_full[7:1] != crc)
                              || !rx_full[0];
              cnt          <= '0;
              state        <= NCC;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        NCC: begin
          if (fall_tick) begin
            if (cnt == 16'(NCC_LEN - 1)) begin
              resp_valid <= 1'b1;
              cmd_ready  <= 1'b1;
              cnt        <= '0;
              state      <= IDLE;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Scoreboard bench for sd_cmd_engine: frame encode, card responses,
// CRC error, timeout, mid-frame reset, CLKDIV=1 back-to-back.
module tb_sd_cmd_engine;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic        crc_err;
    logic        tmo;
    logic        ncc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [5:0]  cmd_index = '0;
  logic [31:0] cmd_arg = '0;
  logic        cmd_resp = 1'b0;
  logic        resp_valid;
  logic [5:0]  resp_index;
  logic [31:0] resp_arg;
  logic        resp_crc_err;
  logic        resp_timeout;
  logic        sd_clk;
  logic        sd_cmd_o;
  logic        sd_cmd_oe;
  logic        sd_cmd_i = 1'b1;

  logic        b_rst = 1'b1;
  logic        b_valid = 1'b0;
  logic        b_ready;
  logic        b_resp_valid;
  logic [5:0]  b_resp_index;
  logic [31:0] b_resp_arg;
  logic        b_crc_err;
  logic        b_tmo;
  logic        b_sd_clk;
  logic        b_o;
  logic        b_oe;

  sd_cmd_engine #(.CLKDIV(2), .NCR_MAX(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_index    (cmd_index),
    .cmd_arg      (cmd_arg),
    .cmd_resp     (cmd_resp),
    .resp_valid   (resp_valid),
    .resp_index   (resp_index),
    .resp_arg     (resp_arg),
    .resp_crc_err (resp_crc_err),
    .resp_timeout (resp_timeout),
    .sd_clk       (sd_clk),
    .sd_cmd_o     (sd_cmd_o),
    .sd_cmd_oe    (sd_cmd_oe),
    .sd_cmd_i     (sd_cmd_i)
  );

  sd_cmd_engine #(.CLKDIV(1), .NCR_MAX(64)) dut_b (
    .clk          (clk),
    .rst          (b_rst),
    .cmd_valid    (b_valid),
    .cmd_ready    (b_ready),
    .cmd_index    (6'd0),
    .cmd_arg      (32'd0),
    .cmd_resp     (1'b0),
    .resp_valid   (b_resp_valid),
    .resp_index   (b_resp_index),
    .resp_arg     (b_resp_arg),
    .resp_crc_err (b_crc_err),
    .resp_timeout (b_tmo),
    .sd_clk       (b_sd_clk),
    .sd_cmd_o     (b_o),
    .sd_cmd_oe    (b_oe),
    .sd_cmd_i     (1'b1)
  );

  int n_run = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [47:0] mkframe(input logic [5:0] idx,
                                          input logic [31:0] arg);
    logic [39:0] h;
    h = {2'b01, idx, arg};
    return {h, crc7(h), 1'b1};
  endfunction

  exp_t        sb[$];
  logic [47:0] fexp[$];

  // Command-side monitor: collect each 48-bit frame while oe is high.
  logic [47:0] fr;
  int          nb = 0;
  always @(posedge sd_clk) begin
    if (sd_cmd_oe === 1'b1) begin
      fr = {fr[46:0], sd_cmd_o};
      nb++;
      if (nb == 48) begin
        if (fexp.size() == 0) chk("spurious_frame", 1, 0);
        else chk("frame", fr, fexp.pop_front());
        nb = 0;
      end
    end else begin
      nb = 0;
    end
  end

  // Response monitor and NCC fall-tick counter.
  logic prev_oe, prev_sd, gap;
  int   nfall = 0;
  int   nresp = 0;
  exp_t e;
  always @(negedge clk) begin
    if (sd_cmd_oe === 1'b1) gap = 1'b0;
    else if (prev_oe === 1'b1) begin
      gap   = 1'b1;
      nfall = 0;
    end else if (gap && prev_sd === 1'b1 && sd_clk === 1'b0) nfall++;
    prev_oe = sd_cmd_oe;
    prev_sd = sd_clk;
    if (resp_valid === 1'b1) begin
      nresp++;
      if (sb.size() == 0) chk("spurious_resp", 1, 0);
      else begin
        e = sb.pop_front();
        chk("resp_index", resp_index, e.idx);
        chk("resp_arg", resp_arg, e.arg);
        chk("resp_crc_err", resp_crc_err, e.crc_err);
        chk("resp_timeout", resp_timeout, e.tmo);
        if (e.ncc) chk("ncc_ticks", nfall, 8);
      end
    end
  end

  // Card model: answers CMD8 three sd_clk after release.
  int          card_mode = 0;
  logic [39:0] rh;
  logic [47:0] rf;
  initial begin
    forever begin
      @(negedge sd_cmd_oe);
      if (card_mode != 0) begin
        rh = {2'b00, 6'd8, 32'h1AA};
        rf = {rh, crc7(rh), 1'b1};
        if (card_mode == 2) rf[8] = ~rf[8];
        repeat (3) @(negedge sd_clk);
        for (int i = 47; i >= 0; i--) begin
          sd_cmd_i = rf[i];
          @(negedge sd_clk);
        end
        sd_cmd_i = 1'b1;
      end
    end
  end

  task automatic issue(input logic [5:0] idx, input logic [31:0] arg,
                       input logic rsp, input logic push,
                       input logic [47:0] frame, input exp_t x);
    int n;
    n = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (cmd_ready !== 1'b1) chk("ready_wait", 0, 1);
    cmd_index = idx;
    cmd_arg   = arg;
    cmd_resp  = rsp;
    cmd_valid = 1'b1;
    if (push) begin
      sb.push_back(x);
      fexp.push_back(frame);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((sb.size() != 0 || fexp.size() != 0) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("done_wait", sb.size() + fexp.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  // CLKDIV=1 back-to-back checks.
  logic [47:0] bfr;
  int          bnb = 0;
  int          b_nframe = 0;
  int          b_nresp = 0;
  int          b_bad = 0;
  int          b_cyc = 0;
  int          b_fall_cyc = -1;
  logic        b_prev_oe, b_prev_sd;
  logic        b_done = 1'b0;

  always @(posedge b_sd_clk) begin
    if (b_oe === 1'b1) begin
      bfr = {bfr[46:0], b_o};
      bnb++;
      if (bnb == 48) begin
        chk("b_frame", bfr, 48'h40_0000_0000_95);
        b_nframe++;
        bnb = 0;
      end
    end else begin
      bnb = 0;
    end
  end

  always @(negedge clk) begin
    if (b_rst === 1'b0) begin
      b_cyc++;
      if (b_cyc > 1 && b_sd_clk === b_prev_sd) b_bad++;
      if (b_prev_oe === 1'b1 && b_oe === 1'b0) b_fall_cyc = b_cyc;
      // 8 NCC fall ticks plus one sd_clk to re-align on a fall tick.
      if (b_prev_oe === 1'b0 && b_oe === 1'b1 && b_fall_cyc >= 0)
        chk("b2b_gap", b_cyc - b_fall_cyc, 18);
      if (b_resp_valid === 1'b1) begin
        b_nresp++;
        chk("b_flags", {b_crc_err, b_tmo}, 0);
      end
    end
    b_prev_oe = b_oe;
    b_prev_sd = b_sd_clk;
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    b_rst   = 1'b0;
    b_valid = 1'b1;
    n = 0;
    while (b_nresp < 3 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    b_valid = 1'b0;
    repeat (300) @(negedge clk);
    chk("b_min3", b_nresp >= 3, 1);
    chk("b_count_match", b_nframe, b_nresp);
    chk("b_clk_div2", b_bad, 0);
    b_done = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  exp_t ez;
  int   n0;
  initial begin
    ez = '{6'd0, 32'd0, 1'b0, 1'b0, 1'b0};
    repeat (4) @(negedge clk);
    chk("rst_pins", {sd_clk, sd_cmd_oe, sd_cmd_o, cmd_ready, resp_valid},
        5'b00110);
    chk("rst_resp", {resp_index, resp_arg, resp_crc_err, resp_timeout}, 0);
    rst = 1'b0;

    issue(6'd0, 32'd0, 1'b0, 1'b1, 48'h40_0000_0000_95,
          '{6'd0, 32'd0, 1'b0, 1'b0, 1'b1});
    wait_done();
    chk("oe_released", sd_cmd_oe, 0);

    card_mode = 1;
    issue(6'd8, 32'h1AA, 1'b1, 1'b1, 48'h48_0000_01AA_87,
          '{6'd8, 32'h1AA, 1'b0, 1'b0, 1'b0});
    wait_done();

    card_mode = 2;
    issue(6'd8, 32'h1AA, 1'b1, 1'b1, 48'h48_0000_01AA_87,
          '{6'd8, 32'h1AB, 1'b1, 1'b0, 1'b0});
    wait_done();

    card_mode = 0;
    issue(6'd8, 32'h1AA, 1'b1, 1'b1, 48'h48_0000_01AA_87,
          '{6'd0, 32'd0, 1'b0, 1'b1, 1'b0});
    wait_done();

    issue(6'd55, 32'hDEAD_0000, 1'b0, 1'b1, mkframe(6'd55, 32'hDEAD_0000),
          '{6'd0, 32'd0, 1'b0, 1'b0, 1'b1});
    repeat (20) @(negedge clk);
    cmd_index = 6'd2;
    cmd_valid = 1'b1;
    repeat (5) @(negedge clk);
    cmd_valid = 1'b0;
    wait_done();

    issue(6'd17, 32'h1234_5678, 1'b1, 1'b0, 48'd0, ez);
    n0 = 0;
    while (nb != 20 && n0 < 2000) begin
      @(negedge clk);
      n0++;
    end
    chk("bit20_reached", nb, 20);
    n0 = nresp;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_oe", sd_cmd_oe, 0);
    chk("rst_mid_ready", cmd_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (600) @(negedge clk);
    chk("rst_no_resp", nresp - n0, 0);

    issue(6'd0, 32'd0, 1'b0, 1'b1, 48'h40_0000_0000_95,
          '{6'd0, 32'd0, 1'b0, 1'b0, 1'b1});
    wait_done();

    n0 = 0;
    while (!b_done && n0 < 5000) begin
      @(negedge clk);
      n0++;
    end
    chk("b_done", b_done, 1);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
